// File: rtl/retire_unit.sv
// In-order retirement stage: updates the retirement RAT, counts retired instructions and
// holds a retired store until the LSU accepts its release. RETIRE_PERF_EN adds class counters.
module retire_unit #(
    parameter int unsigned ARCH_REGS = 32,
    parameter int unsigned PHYS_REGS = 64,
    parameter int unsigned PHYS_W    = $clog2(PHYS_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              commit_valid,
    output logic              commit_ready,
    input  logic              commit_uses_rd,
    input  logic [4:0]        commit_rd_arch,
    input  logic [PHYS_W-1:0] commit_pd_new,
    input  logic [PHYS_W-1:0] commit_pd_old,
    input  logic              commit_is_branch,
    input  logic              commit_is_load,
    input  logic              commit_is_store,
    input  logic              flush_valid,
    output logic              st_commit_valid,
    input  logic              st_commit_ready,
    input  logic [4:0]        rrat_raddr,
    output logic [PHYS_W-1:0] rrat_rdata,
    output logic [63:0]       retire_count,
    output logic              busy
`ifdef RETIRE_PERF_EN
    ,
    output logic [31:0]       br_count,
    output logic [31:0]       ld_count,
    output logic [31:0]       st_count
`endif
);

    localparam int unsigned IDX_W  = $clog2(ARCH_REGS);
    localparam int unsigned CNT_W  = 64;
    localparam int unsigned PERF_W = 32;

    localparam logic [0:0] RUN     = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [0:0]        state;
    logic [0:0]        state_next;
    logic              fire;
    logic              rd_write;
    logic [PHYS_W-1:0] rrat [ARCH_REGS];

    // Flush and reset both take priority over accepting the ROB head.
    assign commit_ready = (state == RUN) && !flush_valid && !rst;
    assign fire         = commit_valid && commit_ready;
    assign rd_write     = fire && commit_uses_rd && (commit_rd_arch != 5'd0)
                          && (32'(commit_rd_arch) < ARCH_REGS);

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (fire && commit_is_store) state_next = ST_WAIT;
            // The store is already architectural, so flush cannot cancel the release.
            ST_WAIT: if (st_commit_ready) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= RUN;
            st_commit_valid <= 1'b0;
            busy            <= 1'b0;
        end else begin
            state           <= state_next;
            st_commit_valid <= (state_next == ST_WAIT);
            busy            <= (state_next == ST_WAIT);
        end
    end

    // Retirement RAT: identity map out of reset, x0 never remapped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < ARCH_REGS; i++) begin
                rrat[IDX_W'(i)] <= PHYS_W'(i);
            end
        end else if (rd_write) begin
            rrat[IDX_W'(commit_rd_arch)] <= commit_pd_new;
        end
    end

    assign rrat_rdata = (32'(rrat_raddr) < ARCH_REGS) ? rrat[IDX_W'(rrat_raddr)] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            retire_count <= '0;
        end else if (fire) begin
            retire_count <= retire_count + CNT_W'(1);
        end
    end

`ifdef RETIRE_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            br_count <= '0;
            ld_count <= '0;
            st_count <= '0;
        end else if (fire) begin
            if (commit_is_branch) br_count <= br_count + PERF_W'(1);
            if (commit_is_load)   ld_count <= ld_count + PERF_W'(1);
            if (commit_is_store)  st_count <= st_count + PERF_W'(1);
        end
    end

    // The old tag is returned to the freelist by the commit/dispatch logic, not here.
    logic unused_pd_old;
    assign unused_pd_old = ^commit_pd_old;
`else
    logic unused_inputs;
    assign unused_inputs = ^{commit_pd_old, commit_is_branch, commit_is_load};
`endif

endmodule

// File: doc/retire_unit.md
RETIRE_UNIT -- requirements
Module: retire_unit

Interface
REQ-001 SHALL have parameter ARCH_REGS, default 32, number of architectural registers.
REQ-002 SHALL have parameter PHYS_REGS, default 64, number of physical registers.
REQ-003 SHALL have parameter PHYS_W, default $clog2(PHYS_REGS), physical tag width.
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-006 SHALL have port commit_valid, input, 1, ROB head entry valid.
REQ-007 SHALL have port commit_ready, output, 1, unit accepts the head entry this cycle.
REQ-008 SHALL have ports commit_uses_rd (input, 1), commit_rd_arch (input, 5), commit_pd_new (input, PHYS_W) and commit_pd_old (input, PHYS_W), carrying head destination info.
REQ-009 SHALL have ports commit_is_branch, commit_is_load and commit_is_store, each input, 1, head class flags.
REQ-010 SHALL have port flush_valid, input, 1, pipeline flush in progress.
REQ-011 SHALL have port st_commit_valid, output, 1, request to LSU to release the oldest store.
REQ-012 SHALL have port st_commit_ready, input, 1, LSU accepts the release.
REQ-013 SHALL have ports rrat_raddr (input, 5) and rrat_rdata (output, PHYS_W), a combinational retirement-RAT read port.
REQ-014 SHALL have port retire_count, output, 64, count of retired instructions.
REQ-015 SHALL have port busy, output, 1, high while state is ST_WAIT.

Function
REQ-016 SHALL define "commit fire" as commit_valid && commit_ready in the same cycle.
REQ-017 SHALL implement FSM states RUN and ST_WAIT.
REQ-018 SHALL drive commit_ready = (state==RUN) && !flush_valid.
REQ-019 SHALL, on fire with commit_uses_rd=1 and commit_rd_arch!=0, write rrat[commit_rd_arch] <= commit_pd_new.
REQ-020 SHALL never write rrat[0]; x0 commits still count as retired.
REQ-021 SHALL make the rrat write visible on rrat_rdata the cycle after fire, with no same-cycle bypass.
REQ-022 SHALL increment retire_count by 1 on every fire, wrapping modulo 2^64.
REQ-023 SHALL, on fire with commit_is_store=1, move RUN->ST_WAIT and assert st_commit_valid from the next cycle.
REQ-024 SHALL hold st_commit_valid high in ST_WAIT until st_commit_ready=1, then return to RUN the following cycle with st_commit_valid=0.
REQ-025 SHALL retire at most one instruction per cycle; a back-to-back store cannot fire until the previous store handshake completes.
REQ-026 SHALL NOT abort ST_WAIT on flush_valid, because the store is already architectural.
REQ-027 SHALL block commit_ready while flush_valid=1 (no fire), leaving rrat and counters untouched.
REQ-028 SHALL, if flush_valid and commit_valid are both high, give flush priority (commit_ready=0).
REQ-029 SHALL keep commit_pd_old unused internally; freelist release is owned by the commit/dispatch system.

Reset
REQ-030 SHALL, while rst=1, set rrat[i]=i for i<ARCH_REGS, state=RUN, retire_count=0, st_commit_valid=0, busy=0.
REQ-031 SHALL drive commit_ready=0 during a reset cycle.
REQ-032 SHALL, on reset in ST_WAIT, drop the pending store request with no handshake completion.

Configuration
REQ-033 SHALL, with macro RETIRE_PERF_EN defined, add outputs br_count, ld_count and st_count (32 bits each, reset 0, wrapping), each incrementing on fire of a branch, load or store respectively.
REQ-034 SHALL, without RETIRE_PERF_EN, omit those ports and counters, leaving all other behaviour identical.

Verification
REQ-035 SHALL cover reset: rst=1 for 1 cycle, then read rrat_raddr=5 -> rrat_rdata=5, retire_count=0, commit_ready=1.
REQ-036 SHALL cover ALU retire: fire with uses_rd=1, rd_arch=3, pd_new=40 -> next cycle rrat[3]=40, retire_count=1.
REQ-037 SHALL cover x0 commit: fire with uses_rd=1, rd_arch=0, pd_new=50 -> rrat[0] stays 0, retire_count increments.
REQ-038 SHALL cover store handshake: store fires, st_commit_ready held 0 for 3 cycles -> st_commit_valid=1 and commit_ready=0 for 3 cycles; one cycle after st_commit_ready=1 -> RUN, commit_ready=1.
REQ-039 SHALL cover flush: flush_valid=1 with commit_valid=1 -> commit_ready=0, no rrat/count change; flush_valid=1 in ST_WAIT -> store handshake still completes.
REQ-040 SHALL cover perf counters under RETIRE_PERF_EN: retire 2 branches, 1 load, 1 store -> br_count=2, ld_count=1, st_count=1, retire_count=4.
